dct_block_collector: RTL

DCT_BLOCK_COLLECTOR -- requirements
Module: dct_block_collector

---
 rtl/dct_block_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dct_block_collector.sv
// dct_block_collector: serial-to-block collector with ping-pong banks.
// Samples arrive one per cycle on in_data/in_valid/in_ready and fill the
// write bank. A complete block of N samples is presented in parallel on
// out_data with out_valid/out_ready, while the other bank keeps filling.
// All state updates on the falling edge of clk; clr_n is an async active-low
// reset.
// Ports:
//   clk, clr_n                  clock (falling edge active), reset
//   in_valid/in_ready/in_data   serial sample stream (W bits)
//   flush                       close a partial block (DCT_FLUSH_EN only)
//   out_valid/out_ready         block handshake
//   out_data                    N*W packed block, sample k at [k*W +: W]
//   out_fill                    valid samples in the presented block
//   fill_idx                    next write index in the filling bank
// Optional feature: define DCT_FLUSH_EN to add the flush port.

// One bank: N x W storage, full flag and fill count.
module dct_bank #(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int IW = 3
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [W-1:0]          wr_data,
  input  logic                  close,
  input  logic [IW:0]           close_cnt,
  input  logic                  rel,
  output logic [N-1:0][W-1:0]   data,
  output logic                  full,
  output logic [IW:0]           cnt
);
  // wr_en only fires while the bank is not full and rel only while it is
  // full, so the two branches never compete. Clearing on release keeps the
  // tail of a short (flushed) block reading as zero.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data <= '0;
      full <= 1'b0;
      cnt  <= '0;
    end else if (rel) begin
      data <= '0;
      full <= 1'b0;
      cnt  <= '0;
    end else begin
      if (wr_en) data[wr_idx] <= wr_data;
      if (close) begin
        full <= 1'b1;
        cnt  <= close_cnt;
      end
    end
  end
endmodule

module dct_block_collector #(
  parameter  int N  = 8,
  parameter  int W  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
`ifdef DCT_FLUSH_EN
  input  logic           flush,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic [IW:0]    out_fill,
  output logic [IW-1:0]  fill_idx
);
  logic [1:0]            full;
  logic [1:0][N*W-1:0]   bdata;
  logic [1:0][IW:0]      bcnt;
  logic                  wsel, rsel;
  logic [IW-1:0]         widx;
  logic                  accept, rel, complete, fl_close, close;
  logic [IW:0]           c, close_cnt;

  assign in_ready = ~full[wsel];
  assign accept   = in_valid & in_ready;
  assign rel      = out_valid & out_ready;

  // Post-accept count: a sample taken on a flush edge is part of the block.
  assign c        = {1'b0, widx} + (IW+1)'(accept);
  assign complete = accept && (widx == IW'(N-1));

`ifdef DCT_FLUSH_EN
  assign fl_close = flush && in_ready && (c != '0) && (c < (IW+1)'(N));
`else
  assign fl_close = 1'b0;
`endif

  assign close     = complete | fl_close;
  assign close_cnt = complete ? (IW+1)'(N) : c;

  // Closing targets wsel (not full) and release targets rsel (full), so
  // both can land on the same edge without touching the same bank.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_bank #(.N(N), .W(W), .IW(IW)) u_bank (
      .clk       (clk),
      .clr_n     (clr_n),
      .wr_en     (accept && (wsel == 1'(b))),
      .wr_idx    (widx),
      .wr_data   (in_data),
      .close     (close && (wsel == 1'(b))),
      .close_cnt (close_cnt),
      .rel       (rel && (rsel == 1'(b))),
      .data      (bdata[b]),
      .full      (full[b]),
      .cnt       (bcnt[b])
    );
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      widx <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
    end else begin
      widx <= close ? '0 : widx + IW'(accept);
      wsel <= wsel ^ close;
      rsel <= rsel ^ rel;
    end
  end

  assign out_valid = full[rsel];
  assign out_data  = bdata[rsel];
  assign out_fill  = bcnt[rsel];
  assign fill_idx  = widx;
endmodule
